// File: rtl/reg_dump_unit.sv
// Debug register dumper: on start, reads every bank register in turn and streams
// each word MSB-first, one byte at a time, through a uart_tx start/done handshake.
module reg_dump_unit #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] rd_reg_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_start_o,
  input  logic                  tx_done_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_reg_q, rd_reg_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] shifted_word;

  assign shifted_word = word_q << 8;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      rd_reg_q   <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_reg_q   <= rd_reg_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // tx_start/tx_data/done are computed one state early so they are registered
  // and line up exactly with the SEND and DONE cycles.
  always_comb begin
    state_d    = state_q;
    rd_reg_d   = rd_reg_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_LOAD;
          rd_reg_d = '0;
          busy_d   = 1'b1;
        end
      end
      S_LOAD: begin
        word_d     = rd_data_i;
        byte_cnt_d = '0;
        tx_data_d  = rd_data_i[DATA_WIDTH-1 -: 8];
        tx_start_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_i) begin
          if (byte_cnt_q != LAST_BYTE) begin
            word_d     = shifted_word;
            byte_cnt_d = byte_cnt_q + 1'b1;
            tx_data_d  = shifted_word[DATA_WIDTH-1 -: 8];
            tx_start_d = 1'b1;
            state_d    = S_SEND;
          end else if (rd_reg_q != LAST_REG) begin
            rd_reg_d = rd_reg_q + 1'b1;
            state_d  = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d   = 1'b0;
        rd_reg_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_reg_o   = rd_reg_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
